// File: rtl/green_phase_scheduler.sv
// Two-approach green-time scheduler for the A/B intersection.
// Sequences green, yellow, all-red and manual override phases, shares the
// right-of-way between approaches A and B on latched demand, and drives the
// per-approach light codes plus a two-digit BCD remaining-time display.
// One CLK cycle is one second of signal time. All outputs are registered and
// change on the same edge as the phase they describe.
module green_phase_scheduler #(
   parameter int MAX_GREEN_A = 90,
   parameter int MAX_GREEN_B = 30,
   parameter int MIN_GREEN   = 10,
   parameter int YELLOW      = 3,
   parameter int ALL_RED     = 2
) (
   input  logic       CLK,
   input  logic       R,
   input  logic       A_Req,
   input  logic       B_Req,
   input  logic       Force_A,
   input  logic       Force_B,
   output logic [1:0] A_Light,
   output logic [1:0] B_Light,
   output logic [3:0] Time_H,
   output logic [3:0] Time_L,
   output logic [2:0] Phase
);

   typedef enum logic [2:0] {
      INIT     = 3'd0,
      A_GREEN  = 3'd1,
      A_YELLOW = 3'd2,
      RED_AB   = 3'd3,
      B_GREEN  = 3'd4,
      B_YELLOW = 3'd5,
      RED_BA   = 3'd6,
      MANUAL   = 3'd7
   } state_t;

   localparam logic [1:0] LIGHT_RED    = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_GREEN  = 2'b10;

   localparam logic [6:0] MAX_A_REM   = 7'(MAX_GREEN_A);
   localparam logic [6:0] MAX_B_REM   = 7'(MAX_GREEN_B);
   localparam logic [6:0] YELLOW_REM  = 7'(YELLOW);
   localparam logic [6:0] ALL_RED_REM = 7'(ALL_RED);

   // Elapsed green = MAX - rem + 1, so "elapsed >= MIN_GREEN" is the same as
   // "rem <= MAX - MIN_GREEN + 1"; comparing rem avoids a subtractor.
   localparam logic [6:0] A_GAP_REM = 7'(MAX_GREEN_A - MIN_GREEN + 1);
   localparam logic [6:0] B_GAP_REM = 7'(MAX_GREEN_B - MIN_GREEN + 1);

   state_t     state;
   state_t     state_n;
   logic [6:0] rem;
   logic [6:0] rem_n;
   logic       a_call;
   logic       a_call_n;
   logic       b_call;
   logic       b_call_n;
   logic       force_any;
   logic [1:0] a_light_n;
   logic [1:0] b_light_n;
   logic [3:0] time_h_n;
   logic [3:0] time_l_n;
   logic [7:0] bcd_n;

   // Binary (0..99) to two BCD digits by bounded repeated subtraction.
   function automatic logic [7:0] to_bcd(input logic [6:0] bin);
      logic [6:0] units;
      logic [3:0] tens;
      units = bin;
      tens  = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (units >= 7'd10) begin
            units = units - 7'd10;
            tens  = tens + 4'd1;
         end
      end
      return {tens, units[3:0]};
   endfunction

   assign force_any = Force_A | Force_B;
   assign Phase     = state;

   // Next phase, remaining counter, call latches and next output values.
   always_comb begin
      state_n   = state;
      rem_n     = (rem > 7'd1) ? rem - 7'd1 : rem;
      a_call_n  = a_call;
      b_call_n  = b_call;
      a_light_n = LIGHT_RED;
      b_light_n = LIGHT_RED;
      time_h_n  = 4'd0;
      time_l_n  = 4'd0;
      bcd_n     = 8'd0;

      case (state)
         INIT: begin
            state_n = RED_BA;
            rem_n   = ALL_RED_REM;
         end
         RED_BA: begin
            if (rem == 7'd1) begin
               state_n = A_GREEN;
               rem_n   = MAX_A_REM;
            end
         end
         A_GREEN: begin
            // Yield only to a waiting B call: max-out or gap-out after MIN_GREEN.
            if (b_call && ((rem == 7'd1) || ((rem <= A_GAP_REM) && !A_Req))) begin
               state_n = A_YELLOW;
               rem_n   = YELLOW_REM;
            end
         end
         A_YELLOW: begin
            if (rem == 7'd1) begin
               state_n = RED_AB;
               rem_n   = ALL_RED_REM;
            end
         end
         RED_AB: begin
            if (rem == 7'd1) begin
               state_n = B_GREEN;
               rem_n   = MAX_B_REM;
            end
         end
         B_GREEN: begin
            if (a_call && ((rem == 7'd1) || ((rem <= B_GAP_REM) && !B_Req))) begin
               state_n = B_YELLOW;
               rem_n   = YELLOW_REM;
            end
         end
         B_YELLOW: begin
            if (rem == 7'd1) begin
               state_n = RED_BA;
               rem_n   = ALL_RED_REM;
            end
         end
         MANUAL: begin
            rem_n = 7'd0;
            if (!force_any) begin
               state_n = INIT;
            end
         end
         default: begin
            state_n = INIT;
            rem_n   = 7'd0;
         end
      endcase

      // Manual override pre-empts any phase boundary; INIT always completes.
      if ((state != INIT) && force_any) begin
         state_n = MANUAL;
         rem_n   = 7'd0;
      end

      // Demand latches; entering the served green clears the call and wins
      // over a request on the same edge.
      if (A_Req && (state != A_GREEN)) begin
         a_call_n = 1'b1;
      end
      if (B_Req && (state != B_GREEN)) begin
         b_call_n = 1'b1;
      end
      if ((state_n == A_GREEN) && (state != A_GREEN)) begin
         a_call_n = 1'b0;
      end
      if ((state_n == B_GREEN) && (state != B_GREEN)) begin
         b_call_n = 1'b0;
      end

      case (state_n)
         A_GREEN:  a_light_n = LIGHT_GREEN;
         A_YELLOW: a_light_n = LIGHT_YELLOW;
         B_GREEN:  b_light_n = LIGHT_GREEN;
         B_YELLOW: b_light_n = LIGHT_YELLOW;
         MANUAL: begin
            if (Force_A) begin
               a_light_n = LIGHT_GREEN;
            end else begin
               b_light_n = LIGHT_GREEN;
            end
         end
         default: begin
            a_light_n = LIGHT_RED;
            b_light_n = LIGHT_RED;
         end
      endcase

      if (state_n == MANUAL) begin
         time_h_n = 4'hF;
         time_l_n = 4'hF;
      end else begin
         bcd_n    = to_bcd(rem_n);
         time_h_n = bcd_n[7:4];
         time_l_n = bcd_n[3:0];
      end
   end

   // Phase, counter, call and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (R) begin
         state   <= INIT;
         rem     <= 7'd0;
         a_call  <= 1'b0;
         b_call  <= 1'b0;
         A_Light <= LIGHT_RED;
         B_Light <= LIGHT_RED;
         Time_H  <= 4'd0;
         Time_L  <= 4'd0;
      end else begin
         state   <= state_n;
         rem     <= rem_n;
         a_call  <= a_call_n;
         b_call  <= b_call_n;
         A_Light <= a_light_n;
         B_Light <= b_light_n;
         Time_H  <= time_h_n;
         Time_L  <= time_l_n;
      end
   end

endmodule

// File: tb/tb_green_phase_scheduler.sv
// Scoreboard bench for green_phase_scheduler: two instances (default and
// MAX_GREEN_B = 15) share the same stimulus; an elapsed-time reference model
// predicts every registered output, and a monitor compares after each edge.
module tb_green_phase_scheduler;

   localparam int MAXA  = 90;
   localparam int MAXB1 = 30;
   localparam int MAXB2 = 15;
   localparam int MING  = 10;
   localparam int YEL   = 3;
   localparam int ARED  = 2;

   logic       clk = 1'b0;
   logic       r = 1'b1;
   logic       a_req = 1'b0;
   logic       b_req = 1'b0;
   logic       f_a = 1'b0;
   logic       f_b = 1'b0;
   logic [1:0] al1, bl1, al2, bl2;
   logic [3:0] th1, tl1, th2, tl2;
   logic [2:0] ph1, ph2;

   always #5 clk = ~clk;

   green_phase_scheduler #(.MAX_GREEN_A(MAXA), .MAX_GREEN_B(MAXB1), .MIN_GREEN(MING),
                           .YELLOW(YEL), .ALL_RED(ARED)) dut1 (
      .CLK(clk), .R(r), .A_Req(a_req), .B_Req(b_req), .Force_A(f_a), .Force_B(f_b),
      .A_Light(al1), .B_Light(bl1), .Time_H(th1), .Time_L(tl1), .Phase(ph1));

   green_phase_scheduler #(.MAX_GREEN_A(MAXA), .MAX_GREEN_B(MAXB2), .MIN_GREEN(MING),
                           .YELLOW(YEL), .ALL_RED(ARED)) dut2 (
      .CLK(clk), .R(r), .A_Req(a_req), .B_Req(b_req), .Force_A(f_a), .Force_B(f_b),
      .A_Light(al2), .B_Light(bl2), .Time_H(th2), .Time_L(tl2), .Phase(ph2));

   // Model state: phase number, cycles spent in it (1 on the entry cycle),
   // pending calls and the force levels seen at the last edge.
   typedef struct {
      int ph;
      int el;
      bit ac;
      bit bc;
      bit fa;
      bit fb;
   } mst_t;

   typedef struct packed {
      logic [2:0] ph;
      logic [1:0] al;
      logic [1:0] bl;
      logic [3:0] th;
      logic [3:0] tl;
   } exp_t;

   mst_t m1, m2;
   exp_t q1[$];
   exp_t q2[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cycle = 0;
   bit   ar_r, br_r, fa_r, fb_r, rr_r;
   int   fcnt;

   function automatic mst_t step(input mst_t s, input int maxb, input bit rr,
                                 input bit ar, input bit br, input bit fa, input bit fb);
      mst_t n;
      int   nph;
      n    = s;
      n.fa = fa;
      n.fb = fb;
      if (rr) begin
         n.ph = 0; n.el = 0; n.ac = 1'b0; n.bc = 1'b0;
         return n;
      end
      nph = s.ph;
      case (s.ph)
         0: nph = 6;
         6: if (s.el >= ARED) nph = 1;
         1: if (s.bc && (s.el >= MAXA || (s.el >= MING && !ar))) nph = 2;
         2: if (s.el >= YEL) nph = 3;
         3: if (s.el >= ARED) nph = 4;
         4: if (s.ac && (s.el >= maxb || (s.el >= MING && !br))) nph = 5;
         5: if (s.el >= YEL) nph = 6;
         7: if (!fa && !fb) nph = 0;
         default: nph = 0;
      endcase
      if (s.ph != 0 && (fa || fb)) nph = 7;
      n.ac = s.ac | (ar && s.ph != 1);
      n.bc = s.bc | (br && s.ph != 4);
      if (nph == 1 && s.ph != 1) n.ac = 1'b0;
      if (nph == 4 && s.ph != 4) n.bc = 1'b0;
      n.el = (nph != s.ph) ? 1 : s.el + 1;
      n.ph = nph;
      return n;
   endfunction

   function automatic exp_t expect_out(input mst_t s, input int maxb);
      exp_t e;
      int   dur;
      int   rem;
      e.ph = 3'(s.ph); e.al = 2'b00; e.bl = 2'b00; e.th = 4'd0; e.tl = 4'd0;
      dur = 1;
      case (s.ph)
         1: begin e.al = 2'b10; dur = MAXA; end
         2: begin e.al = 2'b01; dur = YEL; end
         3: dur = ARED;
         4: begin e.bl = 2'b10; dur = maxb; end
         5: begin e.bl = 2'b01; dur = YEL; end
         6: dur = ARED;
         7: begin
            if (s.fa) e.al = 2'b10;
            else if (s.fb) e.bl = 2'b10;
         end
         default: dur = 1;
      endcase
      if (s.ph == 7) begin
         e.th = 4'hF; e.tl = 4'hF;
      end else if (s.ph != 0) begin
         rem = dur - s.el + 1;
         if (rem < 1) rem = 1;
         e.th = 4'(rem / 10);
         e.tl = 4'(rem % 10);
      end
      return e;
   endfunction

   // Apply one cycle of inputs and queue what each DUT must show after the edge.
   task automatic cyc(input bit rr, input bit ar, input bit br, input bit fa, input bit fb);
      @(posedge clk);
      #2;
      r = rr; a_req = ar; b_req = br; f_a = fa; f_b = fb;
      m1 = step(m1, MAXB1, rr, ar, br, fa, fb);
      m2 = step(m2, MAXB2, rr, ar, br, fa, fb);
      q1.push_back(expect_out(m1, MAXB1));
      q2.push_back(expect_out(m2, MAXB2));
   endtask

   // Monitor: compare both DUTs against the oldest pending expectation.
   initial begin
      exp_t e;
      exp_t g;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (q1.size() > 0) begin
            e = q1.pop_front();
            g = {ph1, al1, bl1, th1, tl1};
            vectors++;
            if (g !== e) begin
               miscompares++;
               $display("FAIL dut1 cycle %0d phase/A/B/TH/TL got %0d/%b/%b/%h/%h want %0d/%b/%b/%h/%h",
                        cycle, g.ph, g.al, g.bl, g.th, g.tl, e.ph, e.al, e.bl, e.th, e.tl);
            end
         end
         if (q2.size() > 0) begin
            e = q2.pop_front();
            g = {ph2, al2, bl2, th2, tl2};
            vectors++;
            if (g !== e) begin
               miscompares++;
               $display("FAIL dut2 cycle %0d phase/A/B/TH/TL got %0d/%b/%b/%h/%h want %0d/%b/%b/%h/%h",
                        cycle, g.ph, g.al, g.bl, g.th, g.tl, e.ph, e.al, e.bl, e.th, e.tl);
            end
         end
      end
   end

   initial begin
      m1 = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      m2 = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset, then continuous demand from both approaches.
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 0);
      repeat (150) cyc(0, 1, 1, 0, 0);

      // A demand only: run into A green rest, then a one-cycle B pulse.
      for (int i = 0; i < 300 && !(m1.ph == 1 && m1.el >= MAXA + 5); i++) cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);
      repeat (8) cyc(0, 1, 0, 0, 0);

      // Gap-out: A_Req low in A green, B pulse at green cycle 3.
      for (int i = 0; i < 300 && m1.ph != 1; i++) cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      repeat (20) cyc(0, 0, 0, 0, 0);

      // Manual override from A green cycle 20.
      for (int i = 0; i < 300 && m1.ph != 1; i++) cyc(0, 1, 1, 0, 0);
      repeat (19) cyc(0, 1, 1, 0, 0);
      repeat (4) cyc(0, 1, 1, 0, 1);
      repeat (3) cyc(0, 1, 1, 1, 1);
      repeat (4) cyc(0, 1, 1, 0, 0);

      // Reset pulse in the middle of B yellow.
      for (int i = 0; i < 400 && m1.ph != 5; i++) cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);
      repeat (6) cyc(0, 1, 1, 0, 0);

      // Randomized demand, override bursts and occasional resets.
      ar_r = 1'b0; br_r = 1'b0; fa_r = 1'b0; fb_r = 1'b0; fcnt = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) ar_r = ~ar_r;
         if ($urandom_range(0, 5) == 0) br_r = ~br_r;
         if (fcnt > 0) begin
            fcnt--;
            if (fcnt == 0) begin
               fa_r = 1'b0; fb_r = 1'b0;
            end
         end else if ($urandom_range(0, 149) == 0) begin
            fcnt = $urandom_range(2, 8);
            fa_r = ($urandom_range(0, 1) == 1);
            fb_r = !fa_r || ($urandom_range(0, 1) == 1);
         end
         rr_r = ($urandom_range(0, 699) == 0);
         cyc(rr_r, ar_r, br_r, fa_r, fb_r);
      end

      @(posedge clk);
      #5;
      vectors++;
      if (q1.size() != 0 || q2.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending got %0d/%0d want 0/0", q1.size(), q2.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/green_phase_scheduler.md
# green_phase_scheduler

Two-approach green-time scheduler for the A/B intersection. It sequences the signal phases and shares the single right-of-way between approach A and approach B. The phases are green, yellow, all-red clearance and manual override. Green time per approach is bounded by parameterised minimum and maximum values, and is granted on latched demand from each approach. It drives the per-approach light codes and a two-digit BCD remaining-time display. One `CLK` cycle equals one second of signal time.

## Interface
Parameters:
- MAX_GREEN_A, 90, maximum A green in cycles (10..99)
- MAX_GREEN_B, 30, maximum B green in cycles (10..99)
- MIN_GREEN, 10, minimum green for either approach (1..MAX_GREEN_x)
- YELLOW, 3, yellow duration in cycles (1..99)
- ALL_RED, 2, all-red clearance duration in cycles (1..99)

Ports:
- CLK  in  1  clock; one cycle = one second
- R  in  1  reset; synchronous, active-high
- A_Req  in  1  vehicle/pedestrian demand sensor, approach A (level)
- B_Req  in  1  demand sensor, approach B (level)
- Force_A  in  1  manual override: A green, B red (level)
- Force_B  in  1  manual override: B green, A red (level)
- A_Light  out  2  A signal: 00 red, 01 yellow, 10 green
- B_Light  out  2  B signal, same encoding
- Time_H  out  4  BCD tens of remaining phase cycles; 4'hF = blank
- Time_L  out  4  BCD units of remaining phase cycles; 4'hF = blank
- Phase  out  3  current state encoding

## Operation
- States and `Phase` codes:
  - INIT = 0
  - A_GREEN = 1
  - A_YELLOW = 2
  - RED_AB = 3
  - B_GREEN = 4
  - B_YELLOW = 5
  - RED_BA = 6
  - MANUAL = 7
- Cycle order: INIT → RED_BA → A_GREEN → A_YELLOW → RED_AB → B_GREEN → B_YELLOW → RED_BA → A_GREEN …
- Remaining counter `rem` (7-bit binary, or BCD directly):
  - Loaded with the phase duration on the entry edge.
  - Decrements once per cycle while rem > 1.
  - Holds at 1 otherwise.
- Yellow and all-red phases exit on the edge where rem == 1, so each lasts exactly YELLOW or ALL_RED cycles.
- Call latches:
  - B_Call is set by B_Req == 1 in any state except B_GREEN, and cleared on entry to B_GREEN.
  - A_Call is the mirror: set by A_Req outside A_GREEN, cleared on entry to A_GREEN.
  - A request and a clear on the same edge: the clear wins (the request has been served).
- A_GREEN exits to A_YELLOW on an edge where B_Call == 1 and either of these holds:
  - rem == 1 (max-out), or
  - elapsed green ≥ MIN_GREEN and A_Req == 0 (gap-out).
  - Elapsed green = MAX_GREEN_A − rem + 1.
- B_GREEN uses the same rules with A and B swapped, and MAX_GREEN_B.
- Rest in green: with no opposing call, green holds indefinitely and `rem` holds at 1 (display 01).
- Light codes:
  - A_GREEN drives A = 10, B = 00.
  - A_YELLOW drives A = 01, B = 00.
  - RED_AB, RED_BA and INIT drive 00/00.
  - B phases mirror the A phases.
- Display: Time_H:Time_L = BCD of `rem`. INIT shows 0/0. MANUAL shows F/F.
- MANUAL:
  - Entered from any state except INIT on the edge after Force_A or Force_B goes high.
  - Force_A has priority over Force_B; lights follow the winning force every cycle.
  - No yellow is inserted on entry; this is the operator's responsibility.
  - Exit when both forces are low: MANUAL → INIT. Calls are preserved.

## Timing
- Reset (R = 1 at an edge):
  - Phase = 0, A_Light = B_Light = 00, Time_H = Time_L = 0.
  - Both calls cleared, `rem` = 0.
  - R overrides every other input.
- INIT lasts exactly one cycle after R is released, then RED_BA.
- All outputs are registered: each changes on the same edge as the state change, with one cycle of latency from input to output.
- Green duration with an opposing call present is between MIN_GREEN and MAX_GREEN_x cycles inclusive.
- A request arriving at rem == 1 during rest ends the green on the next edge: the call latches on edge n, and the phase changes on edge n+1.
- Force asserted in the same cycle as a phase boundary: MANUAL wins.

## Test plan
- Reset, then release with A_Req = B_Req = 1 held:
  - Phase sequence 0(1), 6(2), 1(90), 2(3), 3(2), 4(30), 5(3), 6(2), 1.
  - A green display counts 90 → 01.
- A_Req = 1, B_Req = 0:
  - A_GREEN rests and the display holds 01.
  - A one-cycle B_Req pulse gives A_YELLOW two edges later, with display 03.
- Gap-out: in A_GREEN hold A_Req = 0 and pulse B_Req at green cycle 3 → A green lasts exactly 10 cycles.
- Force_B raised at A_GREEN cycle 20:
  - Next edge: Phase = 7, A = 00, B = 10, Time = F/F.
  - Raising Force_A as well switches the lights to A = 10.
  - Dropping both forces → INIT, then RED_BA.
- R asserted for one cycle mid-B_YELLOW → next edge Phase = 0, lights 00/00, calls cleared.
- Parameter override MAX_GREEN_B = 15 with continuous demand → B green lasts 15 cycles and the display starts at 15.
